if_fetch_unit: RTL and testbench

//  Producer side of the IF->ID pipeline register: generates PC, fetches instructions over an SRAM-like

---
 rtl/if_fetch_unit_pkg.sv | 13 +
 rtl/if_fetch_unit_btb.sv | 63 ++++++
 rtl/if_fetch_unit.sv | 103 ++++++++++
 tb/tb_if_fetch_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths, NOP encoding and fetch FSM state type for the IF stage.
package if_fetch_unit_pkg;
    localparam int ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = '0;

    typedef enum logic [1:0] {
        IF_ST_REQ    = 2'd0,
        IF_ST_WAIT   = 2'd1,
        IF_ST_DONE   = 2'd2,
        IF_ST_CANCEL = 2'd3
    } if_state_e;
endpackage

// File: rtl/if_fetch_unit_btb.sv
// if_fetch_unit_btb: direct-mapped branch target buffer with 2-bit counters.
// Lookup is combinational on the old array contents; updates land at the clock edge.
module if_fetch_unit_btb
    import if_fetch_unit_pkg::*;
#(
    parameter int ENTRIES = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_lookup_pc,
    output logic              o_taken,
    output logic [ADDR_W-1:0] o_target,
    input  logic              i_upd_valid,
    input  logic [ADDR_W-1:0] i_upd_pc,
    input  logic              i_upd_taken,
    input  logic [ADDR_W-1:0] i_upd_target
);
    localparam int IW = $clog2(ENTRIES);
    localparam int TW = ADDR_W - IW - 2;

    logic [ENTRIES-1:0] r_valid;
    logic [TW-1:0]      r_tag    [ENTRIES];
    logic [ADDR_W-1:0]  r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];

    logic [IW-1:0] w_lidx, w_uidx;
    logic [TW-1:0] w_ltag, w_utag;
    logic          w_uhit;
    logic [1:0]    w_uctr, w_ctr_next;
    logic          w_unused;

    assign w_lidx   = i_lookup_pc[IW+1:2];
    assign w_ltag   = i_lookup_pc[ADDR_W-1:IW+2];
    assign w_uidx   = i_upd_pc[IW+1:2];
    assign w_utag   = i_upd_pc[ADDR_W-1:IW+2];
    assign w_unused = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign o_taken  = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag) && r_ctr[w_lidx][1];
    assign o_target = r_target[w_lidx];

    assign w_uhit     = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);
    assign w_uctr     = r_ctr[w_uidx];
    // A fresh entry starts weakly biased toward the observed direction.
    assign w_ctr_next = !w_uhit      ? (i_upd_taken ? 2'b10 : 2'b01) :
                        i_upd_taken  ? ((w_uctr == 2'b11) ? 2'b11 : w_uctr + 2'd1) :
                                       ((w_uctr == 2'b00) ? 2'b00 : w_uctr - 2'd1);

    always_ff @(posedge clk) begin
        if (!rst)
            r_valid <= '0;
        else if (i_upd_valid)
            r_valid[w_uidx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst && i_upd_valid) begin
            r_tag[w_uidx] <= w_utag;
            r_ctr[w_uidx] <= w_ctr_next;
            if (!w_uhit || i_upd_taken)
                r_target[w_uidx] <= i_upd_target;
        end
    end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC generation and single-outstanding instruction fetch feeding the IF/ID register.
// Define IF_BTB_EN to add the BTB predictor; otherwise fetch is always sequential.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 32'hBFC0_0000,
    parameter int                BTB_ENTRIES = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              stall_current_stage,
    input  logic              id_mispredict,
    input  logic [ADDR_W-1:0] id_correct_addr,
    input  logic              id_update_valid,
    input  logic [ADDR_W-1:0] id_update_pc,
    input  logic              id_update_taken,
    input  logic [ADDR_W-1:0] id_update_target,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    output logic [ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic              if_pre_taken,
    output logic [ADDR_W-1:0] if_pre_addr,
    output logic              if_stall_req
);
    if_state_e         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst_buf;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target, w_pc_plus4, w_next_pc;

    assign w_redirect = flush | id_mispredict;
    assign w_target   = flush ? flush_pc : id_correct_addr;
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_next_pc  = if_pre_taken ? if_pre_addr : w_pc_plus4;

    assign inst_req     = (r_state == IF_ST_REQ);
    assign inst_addr    = r_pc;
    assign if_pc        = r_pc;
    assign if_inst      = (r_state == IF_ST_DONE) ? r_inst_buf : NOP_INST;
    assign if_stall_req = (r_state != IF_ST_DONE);

`ifdef IF_BTB_EN
    logic              w_btb_taken;
    logic [ADDR_W-1:0] w_btb_target;

    if_fetch_unit_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
        .clk          (clk),
        .rst          (rst),
        .i_lookup_pc  (r_pc),
        .o_taken      (w_btb_taken),
        .o_target     (w_btb_target),
        .i_upd_valid  (id_update_valid),
        .i_upd_pc     (id_update_pc),
        .i_upd_taken  (id_update_taken),
        .i_upd_target (id_update_target)
    );

    assign if_pre_taken = w_btb_taken;
    assign if_pre_addr  = w_btb_taken ? w_btb_target : w_pc_plus4;
`else
    logic w_unused;

    assign w_unused     = ^{id_update_valid, id_update_pc, id_update_taken, id_update_target, BTB_ENTRIES > 0};
    assign if_pre_taken = 1'b0;
    assign if_pre_addr  = w_pc_plus4;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_state    <= IF_ST_REQ;
            r_inst_buf <= NOP_INST;
        end else if (w_redirect) begin
            // An accepted-but-unanswered request must be drained in CANCEL before refetching.
            r_pc <= w_target;
            case (r_state)
                IF_ST_REQ:  r_state <= inst_addr_ok ? IF_ST_CANCEL : IF_ST_REQ;
                IF_ST_DONE: r_state <= IF_ST_REQ;
                default:    r_state <= inst_data_ok ? IF_ST_REQ : IF_ST_CANCEL;
            endcase
        end else begin
            case (r_state)
                IF_ST_REQ: if (inst_addr_ok) r_state <= IF_ST_WAIT;
                IF_ST_WAIT: if (inst_data_ok) begin
                    r_inst_buf <= inst_rdata;
                    r_state    <= IF_ST_DONE;
                end
                IF_ST_DONE: if (!stall_current_stage) begin
                    r_pc    <= w_next_pc;
                    r_state <= IF_ST_REQ;
                end
                default: if (inst_data_ok) r_state <= IF_ST_REQ;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scripted bus responder with a delivery scoreboard for if_fetch_unit.
module tb_if_fetch_unit;
`ifdef IF_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = '0;
    logic        stall_current_stage = 1'b0;
    logic        id_mispredict = 1'b0;
    logic [31:0] id_correct_addr = '0;
    logic        id_update_valid = 1'b0;
    logic [31:0] id_update_pc = '0;
    logic        id_update_taken = 1'b0;
    logic [31:0] id_update_target = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic [31:0] if_pc, if_inst, if_pre_addr;
    logic        if_pre_taken, if_stall_req;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_stall = 1'b1;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
        .stall_current_stage(stall_current_stage),
        .id_mispredict(id_mispredict), .id_correct_addr(id_correct_addr),
        .id_update_valid(id_update_valid), .id_update_pc(id_update_pc),
        .id_update_taken(id_update_taken), .id_update_target(id_update_target),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .if_pc(if_pc), .if_inst(if_inst), .if_pre_taken(if_pre_taken),
        .if_pre_addr(if_pre_addr), .if_stall_req(if_stall_req)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a - 32'hBFC0_0000) ^ 32'h2402_0001;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Each entry into DONE must deliver exactly the next queued instruction.
    always @(negedge clk) begin
        if (rst && !if_stall_req && prev_stall) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                check("deliver_pc", if_pc, e.pc);
                check("deliver_inst", if_inst, e.inst);
            end
        end
        prev_stall = if_stall_req || !rst;
    end

    task automatic req_accept(input logic [31:0] a);
        for (int i = 0; i < 20 && !inst_req; i++) tick();
        check("req_seen", inst_req, 1);
        check("req_addr", inst_addr, a);
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
    endtask

    task automatic give_data(input logic [31:0] d);
        inst_data_ok = 1'b1;
        inst_rdata   = d;
        tick();
        inst_data_ok = 1'b0;
    endtask

    task automatic fetch_ok(input logic [31:0] a);
        exp_t e;
        req_accept(a);
        tick();
        e.pc   = a;
        e.inst = inst_of(a);
        sb.push_back(e);
        give_data(inst_of(a));
        check("done_stall", if_stall_req, 0);
        check("done_noreq", inst_req, 0);
    endtask

    task automatic redirect(input logic [31:0] a);
        id_mispredict   = 1'b1;
        id_correct_addr = a;
        tick();
        id_mispredict   = 1'b0;
    endtask

    task automatic btb_update(input logic taken);
        for (int i = 0; i < 2; i++) begin
            id_update_valid  = 1'b1;
            id_update_pc     = 32'hBFC0_0010;
            id_update_taken  = taken;
            id_update_target = 32'hBFC0_0040;
            tick();
        end
        id_update_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_req", inst_req, 1);
        check("rst_addr", inst_addr, 32'hBFC0_0000);
        check("rst_inst", if_inst, 0);
        check("rst_stall", if_stall_req, 1);
        check("rst_pre_taken", if_pre_taken, 0);
        rst = 1'b1;

        fetch_ok(32'hBFC0_0000);
        check("seq_pre_addr", if_pre_addr, 32'hBFC0_0004);
        stall_current_stage = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_pc", if_pc, 32'hBFC0_0000);
            check("hold_inst", if_inst, 32'h2402_0001);
            check("hold_noreq", inst_req, 0);
        end
        stall_current_stage = 1'b0;
        tick();
        check("release_req", inst_req, 1);
        check("release_addr", inst_addr, 32'hBFC0_0004);

        fetch_ok(32'hBFC0_0004);
        tick();

        req_accept(32'hBFC0_0008);
        redirect(32'h8000_0100);
        check("cancel_stall", if_stall_req, 1);
        check("cancel_pc", if_pc, 32'h8000_0100);
        check("cancel_inst", if_inst, 0);
        check("cancel_noreq", inst_req, 0);
        give_data(32'hDEAD_BEEF);
        check("drop_inst", if_inst, 0);
        check("drop_req", inst_req, 1);
        fetch_ok(32'h8000_0100);
        tick();

        inst_addr_ok = 1'b1;
        redirect(32'h8000_0300);
        inst_addr_ok = 1'b0;
        check("reqacc_cancel", inst_req, 0);
        check("reqacc_pc", if_pc, 32'h8000_0300);
        redirect(32'h8000_0400);
        check("cancel_latest", if_pc, 32'h8000_0400);
        check("cancel_hold", inst_req, 0);
        give_data(32'hDEAD_BEEF);
        fetch_ok(32'h8000_0400);
        tick();

        flush    = 1'b1;
        flush_pc = 32'hBFC0_0380;
        redirect(32'h8000_0500);
        flush    = 1'b0;
        check("flush_wins", inst_addr, 32'hBFC0_0380);
        fetch_ok(32'hBFC0_0380);
        redirect(32'hFFFF_FFFC);
        check("done_redir_req", inst_req, 1);
        check("done_redir_inst", if_inst, 0);
        check("done_redir_addr", inst_addr, 32'hFFFF_FFFC);

        fetch_ok(32'hFFFF_FFFC);
        tick();
        check("wrap_addr", inst_addr, 32'h0000_0000);
        fetch_ok(32'h0000_0000);
        tick();

        btb_update(1'b1);
        redirect(32'hBFC0_0010);
        check("btb_taken", if_pre_taken, BTB);
        check("btb_pre_addr", if_pre_addr, BTB ? 32'hBFC0_0040 : 32'hBFC0_0014);
        fetch_ok(32'hBFC0_0010);
        tick();
        check("btb_next_req", inst_addr, BTB ? 32'hBFC0_0040 : 32'hBFC0_0014);
        btb_update(1'b0);
        redirect(32'hBFC0_0010);
        check("btb_nt_taken", if_pre_taken, 0);
        check("btb_nt_addr", if_pre_addr, 32'hBFC0_0014);

        tick();
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
